// File: rtl/text_overlay.sv
// Pipelined text-overlay generator: draws a COLS x ROWS grid of scaled 8x16 glyphs
// from a writable character buffer, with per-cell blink and a buffer-clear engine.
module text_overlay #(
    parameter int unsigned COLS         = 16,
    parameter int unsigned ROWS         = 4,
    parameter int unsigned SCALE_SH     = 0,
    parameter int unsigned X0           = 256,
    parameter int unsigned Y0           = 320,
    parameter logic [11:0] FG           = 12'h000,
    parameter logic [11:0] BG           = 12'hFFF,
    parameter int unsigned BLINK_FRAMES = 32,
    parameter int unsigned AW           = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          frame_tick,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          clr,
    output logic          busy,
    output logic [10:0]   rom_addr,
    input  logic [7:0]    rom_data,
    output logic          text_on,
    output logic [11:0]   text_rgb
);
    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned REG_W = COLS * (8 << SCALE_SH);
    localparam int unsigned REG_H = ROWS * (16 << SCALE_SH);
    localparam int unsigned FW    = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          buf_we;
    logic [IW-1:0] buf_wa;
    logic [7:0]    buf_wd;

    // Reset lands in StClear so the buffer is wiped after every reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            StClear: begin
                if (clr) begin
                    ptr_d = '0;
                end else if (ptr_q == IW'(CELLS - 1)) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy   = (state_q == StClear);
        buf_we = 1'b0;
        buf_wa = IW'(wr_addr);
        buf_wd = wr_data;
        if (busy) begin
            buf_we = 1'b1;
            buf_wa = ptr_q;
            buf_wd = 8'h00;
        end else if (wr_en && (32'(wr_addr) < CELLS)) begin
            buf_we = 1'b1;
        end
    end

    logic [FW-1:0] frame_q;
    logic          blink_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
            blink_q <= 1'b0;
        end else if (frame_tick) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_q <= '0;
                blink_q <= ~blink_q;
            end else begin
                frame_q <= frame_q + 1'b1;
            end
        end
    end

    // S0: unsigned offsets, so pixels left of / above the origin wrap and fall outside.
    logic [31:0]   rx, ry;
    logic          in_s0;
    logic [IW-1:0] rd_addr;

    assign rx      = 32'(x) - X0;
    assign ry      = 32'(y) - Y0;
    assign in_s0   = (rx < REG_W) && (ry < REG_H);
    assign rd_addr = IW'((ry >> (4 + SCALE_SH)) * COLS + (rx >> (3 + SCALE_SH)));

    logic [7:0] mem [CELLS];
    logic [7:0] rd_q;

    // Read-before-write: a same-cycle read of the written cell returns the old byte.
    always_ff @(posedge clk) begin
        if (buf_we) mem[buf_wa] <= buf_wd;
        rd_q <= mem[rd_addr];
    end

    logic        in_s1_q, in_s2_q, attr_s2_q, glyph_on;
    logic [2:0]  bit_s1_q, bit_s2_q;
    logic [3:0]  grow_s1_q;
    logic [10:0] rom_addr_q;
    logic        text_on_q;
    logic [11:0] text_rgb_q;

    // Outside the region rom_addr keeps the last in-region address.
    assign rom_addr = in_s1_q ? {rd_q[6:0], grow_s1_q} : rom_addr_q;
    assign glyph_on = in_s2_q && rom_data[3'd7 - bit_s2_q] && !(attr_s2_q && blink_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_s1_q    <= 1'b0;
            bit_s1_q   <= '0;
            grow_s1_q  <= '0;
            in_s2_q    <= 1'b0;
            bit_s2_q   <= '0;
            attr_s2_q  <= 1'b0;
            rom_addr_q <= '0;
            text_on_q  <= 1'b0;
            text_rgb_q <= BG;
        end else begin
            in_s1_q    <= in_s0;
            bit_s1_q   <= rx[SCALE_SH +: 3];
            grow_s1_q  <= ry[SCALE_SH +: 4];
            in_s2_q    <= in_s1_q;
            bit_s2_q   <= bit_s1_q;
            attr_s2_q  <= rd_q[7];
            rom_addr_q <= rom_addr;
            text_on_q  <= glyph_on;
            text_rgb_q <= glyph_on ? FG : BG;
        end
    end

    assign text_on  = text_on_q;
    assign text_rgb = text_rgb_q;

endmodule

// File: tb/tb_text_overlay.sv
// Self-checking bench for text_overlay: two instances (unscaled and 2x) against a
// cycle-indexed reference model of the buffer, clear engine, blink and pixel rules.
module tb_text_overlay;
    localparam int CELLS = 64;

    logic        clk = 1'b0;
    logic        reset, frame_tick, wr_en, clr;
    logic [9:0]  x, y;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy_a, busy_b, on_a, on_b;
    logic [10:0] ra_a, ra_b;
    logic [7:0]  rd_a, rd_b;
    logic [11:0] rgb_a, rgb_b;

    always #5 clk = ~clk;

    text_overlay #(.AW(7)) dut_a (
        .clk(clk), .reset(reset), .x(x), .y(y), .frame_tick(frame_tick),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr), .busy(busy_a),
        .rom_addr(ra_a), .rom_data(rd_a), .text_on(on_a), .text_rgb(rgb_a)
    );

    text_overlay #(.SCALE_SH(1), .X0(0), .Y0(0), .AW(7)) dut_b (
        .clk(clk), .reset(reset), .x(x), .y(y), .frame_tick(frame_tick),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr), .busy(busy_b),
        .rom_addr(ra_b), .rom_data(rd_b), .text_on(on_b), .text_rgb(rgb_b)
    );

    // Synchronous ascii_rom models.
    logic [7:0] font [2048];
    always @(posedge clk) rd_a <= font[ra_a];
    always @(posedge clk) rd_b <= font[ra_b];

    typedef struct packed {
        logic        inr;
        logic        g;
        logic        attr;
        logic [10:0] ra;
    } pix_t;

    typedef struct {
        int          px;
        int          py;
        logic        exp_on;
        logic        chk_ra;
        logic [10:0] exp_ra;
    } vec_t;

    logic [7:0] mbuf [CELLS];
    logic       clr_on, blink_m;
    int         clr_k, ticks, cyc, checks, errors, n, cnt;
    pix_t       ha [8];
    pix_t       hb [8];
    logic       bh [8];
    vec_t       tv [13];
    logic       pa_on, pb_on;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic pix_t model_pix(int xx, int yy, int s, int x0, int y0);
        pix_t       p;
        int         rx, ry, cw, ch;
        logic [7:0] c;
        p  = '0;
        cw = 8 << s;
        ch = 16 << s;
        rx = xx - x0;
        ry = yy - y0;
        if (rx >= 0 && rx < 16 * cw && ry >= 0 && ry < 4 * ch) begin
            c      = mbuf[(ry / ch) * 16 + rx / cw];
            p.inr  = 1'b1;
            p.attr = c[7];
            p.ra   = {c[6:0], 4'((ry >> s) % 16)};
            p.g    = font[p.ra][3'(7 - (rx >> s) % 8)];
        end
        return p;
    endfunction

    // One clock cycle: record the presented pixel, check outputs, advance the model.
    task automatic step();
        pix_t oa, ob;
        int   i0, i1, i3;
        logic ea, eb;
        i0 = cyc % 8;
        i1 = (cyc + 7) % 8;
        i3 = (cyc + 5) % 8;
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                ha[k] = '0;
                hb[k] = '0;
            end
        end else begin
            ha[i0] = model_pix(int'(x), int'(y), 0, 256, 320);
            hb[i0] = model_pix(int'(x), int'(y), 1, 0, 0);
        end
        bh[i0] = blink_m;
        if (cyc >= 3) begin
            oa = ha[i3];
            ob = hb[i3];
            ea = !reset && oa.inr && oa.g && !(oa.attr && bh[i1]);
            eb = !reset && ob.inr && ob.g && !(ob.attr && bh[i1]);
            check("text_on_a", on_a, ea);
            check("text_rgb_a", rgb_a, ea ? 12'h000 : 12'hFFF);
            check("text_on_b", on_b, eb);
            check("text_rgb_b", rgb_b, eb ? 12'h000 : 12'hFFF);
            if (!reset && ha[i1].inr) check("rom_addr_a", ra_a, ha[i1].ra);
            if (!reset && hb[i1].inr) check("rom_addr_b", ra_b, hb[i1].ra);
        end
        check("busy_a", busy_a, reset ? 1'b1 : clr_on);
        check("busy_b", busy_b, reset ? 1'b1 : clr_on);
        @(posedge clk);
        if (reset) begin
            clr_on = 1'b1;
            clr_k  = 0;
            ticks  = 0;
        end else begin
            if (clr_on) mbuf[clr_k] = 8'h00;
            else if (wr_en && wr_addr < CELLS) mbuf[wr_addr] = wr_data;
            if (clr) begin
                clr_on = 1'b1;
                clr_k  = 0;
            end else if (clr_on) begin
                clr_k++;
                if (clr_k == CELLS) clr_on = 1'b0;
            end
            if (frame_tick) ticks++;
        end
        blink_m = 1'((ticks / 32) % 2);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wr(int a, logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 7'(a);
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic probe(int px, int py, output logic oa, output logic ob);
        x = 10'(px);
        y = 10'(py);
        step();
        x = 10'd1023;
        y = 10'd1023;
        step();
        step();
        oa = on_a;
        ob = on_b;
    endtask

    task automatic count_busy();
        n = 0;
        while (busy_a && n < 200) begin
            n++;
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) font[i] = (i < 16) ? 8'h00 : 8'($urandom);
        font[11'h410] = 8'h00; font[11'h411] = 8'h00; font[11'h412] = 8'h10;
        font[11'h413] = 8'h38; font[11'h414] = 8'h6C; font[11'h415] = 8'hC6;
        font[11'h416] = 8'hC6; font[11'h417] = 8'hFE; font[11'h418] = 8'hC6;
        font[11'h419] = 8'hC6; font[11'h41A] = 8'hC6; font[11'h41B] = 8'hC6;
        for (int i = 12; i < 16; i++) font[11'h410 + i] = 8'h00;
        for (int i = 0; i < CELLS; i++) mbuf[i] = 8'h00;

        tv[0]  = '{259, 322, 1'b1, 1'b1, 11'h412};
        tv[1]  = '{256, 322, 1'b0, 1'b1, 11'h412};
        tv[2]  = '{256, 327, 1'b1, 1'b1, 11'h417};
        tv[3]  = '{263, 327, 1'b0, 1'b1, 11'h417};
        tv[4]  = '{257, 325, 1'b1, 1'b1, 11'h415};
        tv[5]  = '{258, 325, 1'b0, 1'b1, 11'h415};
        tv[6]  = '{262, 329, 1'b1, 1'b1, 11'h419};
        tv[7]  = '{260, 335, 1'b0, 1'b1, 11'h41F};
        tv[8]  = '{264, 322, 1'b0, 1'b1, 11'h002};
        tv[9]  = '{255, 322, 1'b0, 1'b0, 11'h000};
        tv[10] = '{384, 322, 1'b0, 1'b0, 11'h000};
        tv[11] = '{259, 384, 1'b0, 1'b0, 11'h000};
        tv[12] = '{259, 319, 1'b0, 1'b0, 11'h000};

        checks = 0; errors = 0; cyc = 0; ticks = 0; clr_on = 1'b1; clr_k = 0;
        blink_m = 1'b0;
        reset = 1'b1; x = 10'd1023; y = 10'd1023; frame_tick = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;
        @(negedge clk);
        repeat (3) step();
        check("reset_text_on", on_a, 1'b0);
        check("reset_text_rgb", rgb_a, 12'hFFF);
        check("reset_rom_addr", ra_a, 11'h000);
        check("reset_busy", busy_a, 1'b1);
        reset = 1'b0;
        count_busy();
        check("busy_len_reset", n, 64);

        // Cleared buffer: whole unscaled region is blank.
        cnt = 0;
        for (int yy = 320; yy < 384; yy++) begin
            for (int xx = 256; xx < 384; xx++) begin
                x = 10'(xx);
                y = 10'(yy);
                step();
                if (on_a) cnt++;
            end
        end
        check("blank_sweep", cnt, 0);

        wr(0, 8'h41);
        wr(64, 8'h00);
        for (int i = 0; i < 13; i++) begin
            x = 10'(tv[i].px);
            y = 10'(tv[i].py);
            step();
            x = 10'd1023;
            y = 10'd1023;
            if (tv[i].chk_ra) check("vec_rom_addr", ra_a, tv[i].exp_ra);
            step();
            step();
            check("vec_text_on", on_a, tv[i].exp_on);
            check("vec_text_rgb", rgb_a, tv[i].exp_on ? 12'h000 : 12'hFFF);
        end

        for (int r = 0; r < 16; r++) begin
            for (int b = 0; b < 8; b++) begin
                x = 10'(256 + b);
                y = 10'(320 + r);
                step();
                check("rom_row", ra_a, 11'h410 + 11'(r));
            end
        end

        // Scaled instance: 'A' at cell 1 spans x=16..31.
        wr(1, 8'h41);
        for (int yy = 0; yy < 34; yy++) begin
            for (int xx = 14; xx < 34; xx++) begin
                x = 10'(xx);
                y = 10'(yy);
                step();
            end
        end
        probe(22, 4, pa_on, pb_on);  check("scaled_on", pb_on, 1'b1);
        probe(23, 5, pa_on, pb_on);  check("scaled_2x2", pb_on, 1'b1);
        probe(17, 15, pa_on, pb_on); check("scaled_row7", pb_on, 1'b1);
        probe(16, 4, pa_on, pb_on);  check("scaled_off", pb_on, 1'b0);
        probe(32, 4, pa_on, pb_on);  check("scaled_x32", pb_on, 1'b0);

        // Blink: cell 5 blinks, cell 4 does not.
        wr(4, 8'h41);
        wr(5, 8'hC1);
        for (int t = 1; t <= 64; t++) begin
            frame_tick = 1'b1;
            x = 10'((t % 2) ? 291 : 299);
            y = 10'd322;
            step();
            frame_tick = 1'b0;
            if (t == 31 || t == 64) begin
                probe(299, 322, pa_on, pb_on);
                check("blink_visible", pa_on, 1'b1);
            end
            if (t == 32) begin
                probe(299, 322, pa_on, pb_on);
                check("blink_hidden", pa_on, 1'b0);
                probe(291, 322, pa_on, pb_on);
                check("blink_neighbour", pa_on, 1'b1);
            end
        end

        // Clear with dropped writes and coincident frame ticks.
        clr = 1'b1;
        step();
        clr = 1'b0;
        n = 0;
        while (busy_a && n < 200) begin
            n++;
            wr_en      = (n < 12);
            wr_addr    = 7'($urandom_range(0, 63));
            wr_data    = 8'($urandom);
            frame_tick = (n % 5 == 0);
            x = 10'($urandom_range(256, 383));
            y = 10'($urandom_range(320, 383));
            step();
        end
        wr_en = 1'b0;
        frame_tick = 1'b0;
        check("busy_len_clr", n, 64);
        wr(0, 8'h41);
        probe(259, 322, pa_on, pb_on); check("post_clr_write", pa_on, 1'b1);
        probe(267, 322, pa_on, pb_on); check("post_clr_cell1", pa_on, 1'b0);
        for (int i = 0; i < CELLS; i++) begin
            x = 10'(256 + (i % 16) * 8 + 3);
            y = 10'(320 + (i / 16) * 16 + 2);
            step();
        end

        // clr mid-clear restarts the sweep.
        clr = 1'b1; step(); clr = 1'b0;
        repeat (20) step();
        clr = 1'b1; step(); clr = 1'b0;
        count_busy();
        check("busy_len_restart", n, 64);

        // Reset mid-clear restarts it on release.
        wr(3, 8'h5A);
        clr = 1'b1; step(); clr = 1'b0;
        repeat (10) step();
        reset = 1'b1; step(); step(); reset = 1'b0;
        count_busy();
        check("busy_len_reset_mid", n, 64);

        for (int i = 0; i < 3000; i++) begin
            x          = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(250, 390))
                                                     : 10'($urandom_range(0, 270));
            y          = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(315, 390))
                                                     : 10'($urandom_range(0, 135));
            wr_en      = ($urandom_range(0, 99) < 15);
            wr_addr    = 7'($urandom_range(0, 70));
            wr_data    = 8'($urandom);
            frame_tick = ($urandom_range(0, 99) < 10);
            clr        = ($urandom_range(0, 999) < 3);
            step();
        end
        wr_en = 1'b0; frame_tick = 1'b0; clr = 1'b0;
        x = 10'd1023; y = 10'd1023;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_overlay.md
# text_overlay

Parametrised, pipelined text-overlay generator for the VGA pixel path. It renders a COLS×ROWS grid of 8×16 ASCII glyphs, scaled by 2^SCALE_SH, at a fixed pixel origin. Glyph codes come from a writable character buffer rather than hard-wired case tables. It adds a per-cell blink attribute and a buffer-clear engine, drives an external synchronous ascii_rom, and sits between the pixel-coordinate generator and the final RGB mux.

## Interface
- COLS, 16, characters per text line (1..64)
- ROWS, 4, text lines (1..16)
- SCALE_SH, 0, glyph scale exponent; glyph cell is (8<<SCALE_SH)×(16<<SCALE_SH) pixels (0..2)
- X0, 256, left pixel column of the region
- Y0, 320, top pixel row of the region
- FG, 12'h000, foreground RGB
- BG, 12'hFFF, background RGB
- BLINK_FRAMES, 32, frames per blink half-period (≥1)
- AW, clog2(COLS*ROWS), derived buffer address width

- clk  in  1  pixel-pipeline clock
- reset  in  1  reset; asynchronous and active-high, one clock
- x, y  in  10 each  current pixel coordinate, new value every cycle
- frame_tick  in  1  one-cycle pulse at start of each frame
- wr_en  in  1  write strobe into character buffer
- wr_addr  in  AW  cell index = line*COLS + col
- wr_data  in  8  [7] blink attribute, [6:0] ASCII code
- clr  in  1  pulse: start clearing the whole buffer
- busy  out  1  clear engine active
- rom_addr  out  11  {char[6:0], glyph_row[3:0]} to ascii_rom
- rom_data  in  8  ascii_rom data, valid 1 cycle after rom_addr
- text_on  out  1  pixel lies inside region and glyph bit set
- text_rgb  out  12  FG when text_on, else BG

## Operation
- Region: rx = x−X0, ry = y−Y0; in_region when 0 ≤ rx < COLS·(8<<S) and 0 ≤ ry < ROWS·(16<<S), where S = SCALE_SH. Unsigned compare; coordinates left/above the origin are out of region.
- Cell: col = rx>>(3+S), line = ry>>(4+S), bit = (rx>>S)&7, grow = (ry>>S)&15, index = line*COLS+col.
- Character buffer: COLS·ROWS×8, one write port and one synchronous read port.
  - A write with wr_en=1 and busy=0 lands at the clock edge.
  - wr_en while busy=1 is dropped.
  - wr_addr ≥ COLS·ROWS is dropped.
- Glyph pixel = rom_data[7−bit].
- Blink: when the cell attribute is 1 and blink_phase=1, the glyph pixel is forced to 0.
- Frame counter counts frame_tick pulses 0..BLINK_FRAMES−1. On wrap it toggles blink_phase.
- Clear engine states:
  - IDLE: on clr go to CLEAR with ptr=0.
  - CLEAR: write 8'h00 at ptr and increment ptr each cycle. After writing COLS·ROWS−1, return to IDLE.
  - busy=1 exactly while in CLEAR.
  - clr during CLEAR restarts from ptr=0.
- Reset: enter CLEAR at ptr=0 (auto-clear after reset release). blink_phase=0, frame counter=0, pipeline valid bits cleared.
- Reset asserted mid-clear aborts the clear and restarts it on release.
- Cells read during CLEAR return whatever is currently stored; there is no display blanking.

## Timing
- Pipeline latency from x/y to text_on/text_rgb is 3 cycles; the RGB mux delays its other sources by 3.
  - S0 (x,y presented): region/cell decode is registered, and the buffer read address equals index.
  - S1: buffer data valid; rom_addr is registered from {data[6:0], grow}; in_region, bit and attr are delayed alongside.
  - S2: rom_data valid; text_on/text_rgb are registered at the end of S2 and visible in cycle 3.
- Buffer write to display: a write at edge N is visible for pixels presented at cycle ≥ N+1. Read and write to the same cell in the same cycle return the old data.
- rom_addr is don't-care-stable when not in region; it holds its last value.
- Reset values: text_on=0, text_rgb=BG, rom_addr=0, busy=1 from the first edge after reset release until clear completes (COLS·ROWS cycles).
- frame_tick coincident with a clear is still counted.

## Test plan
- Reset release, defaults: busy stays high exactly 64 cycles, then drops. Sweeping the whole region yields text_on=0 and text_rgb=12'hFFF everywhere.
- Write 8'h41 ('A') at cell 0. Present x=256, y=320+row r for all r. rom_addr must be 11'h410+r one cycle after S0, and text_on must follow ROM row bits 3 cycles after x/y.
- SCALE_SH=1, X0=0, Y0=0, 'A' at cell 1. Each glyph bit must cover 2×2 pixels at x=16..31, y=0..31, and no pixel is drawn at x=32.
- Blink: write 8'hC1 at cell 5 and issue 32 frame_ticks. The glyph must vanish at the 32nd tick, reappear at the 64th, and neighbouring non-blink cells must be unaffected.
- clr pulse mid-display with writes during busy: the writes must be ignored, all cells read 8'h00 after 64 cycles, and a write at cycle 65 must be accepted.
- Boundary: x=X0−1, x=X0+128, y=Y0+64, and out-of-range wr_addr=64 (with COLS=16, ROWS=4 stretched to AW=7). All must give text_on=0 and leave buffer contents unchanged.
